// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per enabled clock.
// Forward key expansion to round key 10, then inverted step by step.
module aes_decrypt #(
    parameter int NUM_ROUNDS  = 10,
    parameter bit DONE_STICKY = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         en,
    input  logic [127:0] cyphertext,
    input  logic [127:0] initial_key,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_decrypt: only NUM_ROUNDS=10 is supported");
    end

    typedef enum logic [1:0] {IDLE, KEXP, ARK0, ROUND} fsm_t;

    fsm_t         fsm;
    logic [127:0] st;
    logic [127:0] key;
    logic [3:0]   rnd;
    logic [127:0] rnd_out;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic         last);
        logic [127:0] t;
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        int           src;
        m[0] = 8'h0e;
        m[1] = 8'h0b;
        m[2] = 8'h0d;
        m[3] = 8'h09;
        t = '0;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
            t[127-8*i -: 8] = inv_sbox(s[127-8*src -: 8]);
        end
        t = t ^ k;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = t[127-8*(4*c+j) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], m[(j - r) & 3]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return last ? t : o;
    endfunction

    // Combinational round datapath on the current state/key
    always_comb begin
        rnd_out = inv_round(st, key, rnd == 4'd0);
    end

    // Control FSM, key schedule and state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm       <= IDLE;
            st        <= '0;
            key       <= '0;
            rnd       <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (en) begin
            if (!DONE_STICKY) done <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (start) begin
                        st   <= cyphertext;
                        key  <= initial_key;
                        rnd  <= 4'd1;
                        busy <= 1'b1;
                        done <= 1'b0;
                        fsm  <= KEXP;
                    end
                end
                KEXP: begin
                    key <= fwd_key(key, rcon(rnd));
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd10) fsm <= ARK0;
                end
                ARK0: begin
                    st  <= st ^ key;
                    key <= inv_key(key, rcon(4'd10));
                    rnd <= 4'd9;
                    fsm <= ROUND;
                end
                ROUND: begin
                    st <= rnd_out;
                    if (rnd != 4'd0) begin
                        key <= inv_key(key, rcon(rnd));
                        rnd <= rnd - 4'd1;
                    end else begin
                        plaintext <= rnd_out;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS vectors, enable gaps, restart, reset,
// and random round trips through a byte-level AES encrypt model.
module tb_aes_decrypt;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         en;
    logic [127:0] ct_in;
    logic [127:0] key_in;
    logic [127:0] pt;
    logic         busy;
    logic         done;
    logic [127:0] pt_s;
    logic         busy_s;
    logic         done_s;

    int total;
    int bad;

    logic [7:0] sb [256];

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;

    aes_decrypt dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .en          (en),
        .cyphertext  (ct_in),
        .initial_key (key_in),
        .plaintext   (pt),
        .busy        (busy),
        .done        (done)
    );

    aes_decrypt #(.DONE_STICKY(1'b1)) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .en          (en),
        .cyphertext  (ct_in),
        .initial_key (key_in),
        .plaintext   (pt_s),
        .busy        (busy_s),
        .done        (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // carry-less product then reduction by x^8+x^4+x^3+x+1
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
                  ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] o;
        logic [127:0] rk;
        rk = rkey(k, 0);
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++)
                t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = mul(t[4*c], 2) ^ mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ mul(t[4*c+1], 2) ^ mul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2], 2) ^ mul(t[4*c+3], 3);
                    s[4*c+3] = mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3], 2);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            rk = rkey(k, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // accept one job and wait for done; tog alternates en every edge
    task automatic run_job(input logic [127:0] c, input logic [127:0] k,
                           input logic [127:0] exp, input bit tog, input string tag);
        int n;
        int off_bad;
        ct_in  = c;
        key_in = k;
        en     = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        ct_in  = {$urandom, $urandom, $urandom, $urandom};
        key_in = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_busy_acc"}, 128'(busy), 128'(1'b1));
        n = 0;
        off_bad = 0;
        while (done !== 1'b1 && n < 40) begin
            if (tog) en = ~en;
            step();
            if (en) n++;
            else if (done !== 1'b0 || busy !== 1'b1) off_bad++;
        end
        en = 1'b1;
        chk({tag, "_latency"}, 128'(n), 128'(21));
        chk({tag, "_pt"}, pt, exp);
        chk({tag, "_busy_end"}, 128'(busy), 128'(1'b0));
        if (tog) chk({tag, "_en_off"}, 128'(off_bad), 128'(0));
    endtask

    initial begin
        logic [127:0] rp;
        logic [127:0] rk;
        int seen;
        total   = 0;
        bad     = 0;
        build_sbox();
        reset_n = 1'b0;
        start   = 1'b0;
        en      = 1'b1;
        ct_in   = '0;
        key_in  = '0;
        step();
        step();
        chk("rst_pt", pt, 128'h0);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        reset_n = 1'b1;
        step();

        // App.B vector, pulse vs sticky done
        run_job(C1, K1, P1, 1'b0, "vec1");
        chk("sticky_first", 128'(done_s), 128'(1'b1));
        step();
        chk("pulse_clear", 128'(done), 128'(1'b0));
        step();
        step();
        chk("sticky_hold", 128'(done_s), 128'(1'b1));
        chk("pt_hold", pt, P1);

        // App.C.1 vector
        run_job(C2, K2, P2, 1'b0, "vec2");

        // en toggling, then done held through en=0 edges
        run_job(C1, K1, P1, 1'b1, "entog");
        en = 1'b0;
        step();
        step();
        chk("done_en0", 128'(done), 128'(1'b1));
        en = 1'b1;
        step();
        chk("done_en1", 128'(done), 128'(1'b0));

        // start held high, inputs swapped after the first accept
        ct_in  = C1;
        key_in = K1;
        start  = 1'b1;
        step();
        ct_in  = C2;
        key_in = K2;
        chk("hold_sticky_clr", 128'(done_s), 128'(1'b0));
        for (int i = 1; i <= 21; i++) begin
            step();
            if (i == 20) chk("hold_busy20", 128'(busy), 128'(1'b1));
        end
        chk("hold_done1", 128'(done), 128'(1'b1));
        chk("hold_busy_gap", 128'(busy), 128'(1'b0));
        chk("hold_pt1", pt, P1);
        step();
        chk("hold_reaccept", 128'(busy), 128'(1'b1));
        chk("hold_done_drop", 128'(done), 128'(1'b0));
        for (int i = 1; i <= 21; i++) step();
        start = 1'b0;
        chk("hold_done2", 128'(done), 128'(1'b1));
        chk("hold_pt2", pt, P2);
        step();

        // async reset in the middle of a job
        ct_in  = C1;
        key_in = K1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_pt", pt, 128'h0);
        chk("arst_busy", 128'(busy), 128'(1'b0));
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("arst_quiet", 128'(seen), 128'(0));
        run_job(C1, K1, P1, 1'b0, "arst_vec1");

        // random round trips through the encrypt model
        for (int j = 0; j < 200; j++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_job(encrypt(rp, rk), rk, rp, (j % 8) == 7, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
